huffman_phase_ctrl: RTL and testbench

Top-level sequencer for the Huffman encoder. It drives the 2-bit `state` bus shared by the frequency counter, the tree builder and `create_node_code`. It collects the symbol stream length, then hand-shakes the tree builder through SYM_NUM-1 merges. Each merged node is written into the node register file that feeds `info_node_1..7`. Finally it releases code generation and reports completion, errors and timeouts.

---
 rtl/huffman_phase_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_huffman_phase_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_phase_ctrl.sv
// Phase sequencer for the Huffman encoder: counts the symbol stream, handshakes
// SYM_NUM-1 tree merges into the node register file, then releases code generation.
module huffman_phase_ctrl #(
  parameter int unsigned SYM_NUM = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        abort,
  input  logic        sym_valid,
  input  logic        sym_last,
  input  logic        merge_done,
  input  logic [12:0] node_in,
  input  logic        code_done,
  output logic [1:0]  state,
  output logic        merge_req,
  output logic        node_we,
  output logic [2:0]  node_addr,
  output logic [12:0] node_data,
  output logic [7:0]  sym_cnt,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error
);

  localparam int unsigned KW = 4;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] K_LAST   = KW'(SYM_NUM - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_BAD_ROOT = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_COUNT = 2'b01;
  localparam logic [1:0] PH_BUILD = 2'b10;
  localparam logic [1:0] PH_CODE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_B_REQ,
    S_B_WAIT,
    S_B_WR,
    S_CODE
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [KW-1:0] k_q, k_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    state_q, state_d;
  logic          merge_req_q, merge_req_d;
  logic          node_we_q, node_we_d;
  logic [2:0]    node_addr_q, node_addr_d;
  logic [12:0]   node_data_q, node_data_d;
  logic [7:0]    sym_cnt_q, sym_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    error_q, error_d;

  logic          timeout_c;
  logic          root_ok_c;

  assign timeout_c = (wait_q == WAIT_MAX);
  // Root node must be parentless (F) and carry the whole frame's weight.
  assign root_ok_c = (node_data_q[12:9] == 4'hF) && (node_data_q[7:0] == sym_cnt_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q       <= S_IDLE;
      k_q         <= '0;
      wait_q      <= '0;
      state_q     <= PH_IDLE;
      merge_req_q <= 1'b0;
      node_we_q   <= 1'b0;
      node_addr_q <= '0;
      node_data_q <= '0;
      sym_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= ERR_OK;
    end else begin
      fsm_q       <= fsm_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      state_q     <= state_d;
      merge_req_q <= merge_req_d;
      node_we_q   <= node_we_d;
      node_addr_q <= node_addr_d;
      node_data_q <= node_data_d;
      sym_cnt_q   <= sym_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    k_d         = k_q;
    wait_d      = '0;
    state_d     = state_q;
    merge_req_d = 1'b0;
    node_we_d   = 1'b0;
    node_addr_d = node_addr_q;
    node_data_d = node_data_q;
    sym_cnt_d   = sym_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;

    if (abort) begin
      fsm_d = S_IDLE;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (start) begin
            sym_cnt_d = '0;
            k_d       = KW'(1);
            error_d   = ERR_OK;
            fsm_d     = S_COUNT;
          end
        end
        S_COUNT: begin
          // Overflow outranks timeout so a 256th symbol is always reported as such.
          if (sym_valid && (sym_cnt_q == 8'hFF)) begin
            error_d = ERR_OVERFLOW;
            fsm_d   = S_IDLE;
          end else begin
            if (sym_valid) begin
              sym_cnt_d = sym_cnt_q + 8'd1;
            end
            if (sym_valid && sym_last) begin
              fsm_d = S_B_REQ;
            end else if (timeout_c) begin
              error_d = ERR_TIMEOUT;
              fsm_d   = S_IDLE;
            end
          end
        end
        S_B_REQ: begin
          fsm_d = S_B_WAIT;
        end
        S_B_WAIT: begin
          if (merge_done) begin
            node_data_d = node_in;
            fsm_d       = S_B_WR;
          end else if (timeout_c) begin
            error_d = ERR_TIMEOUT;
            fsm_d   = S_IDLE;
          end
        end
        S_B_WR: begin
          if (k_q < K_LAST) begin
            k_d   = k_q + KW'(1);
            fsm_d = S_B_REQ;
          end else if (root_ok_c) begin
            fsm_d = S_CODE;
          end else begin
            error_d = ERR_BAD_ROOT;
            fsm_d   = S_IDLE;
          end
        end
        S_CODE: begin
          if (code_done) begin
            done_d = 1'b1;
            fsm_d  = S_IDLE;
          end else if (timeout_c) begin
            error_d = ERR_TIMEOUT;
            fsm_d   = S_IDLE;
          end
        end
        default: begin
          fsm_d = S_IDLE;
        end
      endcase
    end

    // Wait counter restarts on any state change and only runs in waiting states.
    if ((fsm_d == fsm_q) && (fsm_q inside {S_COUNT, S_B_WAIT, S_CODE})) begin
      wait_d = wait_q + WW'(1);
    end

    // Registered outputs are derived from the next state so they line up with it.
    unique case (fsm_d)
      S_IDLE:                   state_d = PH_IDLE;
      S_COUNT:                  state_d = PH_COUNT;
      S_B_REQ, S_B_WAIT, S_B_WR: state_d = PH_BUILD;
      S_CODE:                   state_d = PH_CODE;
      default:                  state_d = PH_IDLE;
    endcase
    busy_d      = (fsm_d != S_IDLE);
    merge_req_d = (fsm_d == S_B_REQ);
    node_we_d   = (fsm_d == S_B_WR);
    if (fsm_d == S_B_WR) begin
      node_addr_d = 3'(k_q);
    end
  end

  assign state     = state_q;
  assign merge_req = merge_req_q;
  assign node_we   = node_we_q;
  assign node_addr = node_addr_q;
  assign node_data = node_data_q;
  assign sym_cnt   = sym_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_huffman_phase_ctrl.sv
// Directed self-checking bench for huffman_phase_ctrl: normal, bad-root, overflow,
// timeout, abort, mid-frame reset and spurious-input scenarios.
module tb_huffman_phase_ctrl;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        abort;
  logic        sym_valid;
  logic        sym_last;
  logic        merge_done;
  logic [12:0] node_in;
  logic        code_done;
  logic [1:0]  state;
  logic        merge_req;
  logic        node_we;
  logic [2:0]  node_addr;
  logic [12:0] node_data;
  logic [7:0]  sym_cnt;
  logic        busy;
  logic        done;
  logic [1:0]  error;

  int checks   = 0;
  int failures = 0;
  int we_seen  = 0;

  logic [12:0] nodes_n [7] = '{13'h001A, 13'h011C, 13'h0222, 13'h032B,
                               13'h043D, 13'h0544, 13'h1F77};
  logic [12:0] nodes_s [7] = '{13'h0002, 13'h0103, 13'h0204, 13'h0302,
                               13'h0403, 13'h0504, 13'h1F05};

  huffman_phase_ctrl #(.SYM_NUM(8), .TIMEOUT(255)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .sym_valid  (sym_valid),
    .sym_last   (sym_last),
    .merge_done (merge_done),
    .node_in    (node_in),
    .code_done  (code_done),
    .state      (state),
    .merge_req  (merge_req),
    .node_we    (node_we),
    .node_addr  (node_addr),
    .node_data  (node_data),
    .sym_cnt    (sym_cnt),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    if (node_we) we_seen++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 16'(state), 16'h0);
    chk({tag, "_mreq"}, 16'(merge_req), 16'h0);
    chk({tag, "_we"}, 16'(node_we), 16'h0);
    chk({tag, "_addr"}, 16'(node_addr), 16'h0);
    chk({tag, "_data"}, 16'(node_data), 16'h0);
    chk({tag, "_cnt"}, 16'(sym_cnt), 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_done"}, 16'(done), 16'h0);
    chk({tag, "_err"}, 16'(error), 16'h0);
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", 16'(state), 16'h1);
    chk("start_busy", 16'(busy), 16'h1);
    chk("start_cnt", 16'(sym_cnt), 16'h0);
    chk("start_err", 16'(error), 16'h0);
  endtask

  task automatic count_syms(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      sym_valid = 1'b1;
      sym_last  = (i == n - 1);
      if (spur && i == 10) begin
        start      = 1'b1;
        merge_done = 1'b1;
      end
      tick();
      start      = 1'b0;
      merge_done = 1'b0;
      if (spur && i == 10) begin
        chk("spur_count_cnt", 16'(sym_cnt), 16'd11);
        chk("spur_count_state", 16'(state), 16'h1);
        chk("spur_count_we", 16'(node_we), 16'h0);
      end
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    chk("count_end_state", 16'(state), 16'h2);
    chk("count_end_mreq", 16'(merge_req), 16'h1);
    chk("count_end_cnt", 16'(sym_cnt), 16'(n));
  endtask

  task automatic do_merge(input int k, input logic [12:0] data, input bit spur, input bit last_ok);
    tick();
    chk("wait_mreq", 16'(merge_req), 16'h0);
    chk("wait_state", 16'(state), 16'h2);
    if (spur) begin
      code_done = 1'b1;
      tick();
      code_done = 1'b0;
      chk("spur_code_state", 16'(state), 16'h2);
      chk("spur_code_done", 16'(done), 16'h0);
    end
    merge_done = 1'b1;
    node_in    = data;
    tick();
    merge_done = 1'b0;
    chk("wr_we", 16'(node_we), 16'h1);
    chk("wr_addr", 16'(node_addr), 16'(k));
    chk("wr_data", 16'(node_data), 16'(data));
    tick();
    if (k < 7) begin
      chk("next_state", 16'(state), 16'h2);
      chk("next_mreq", 16'(merge_req), 16'h1);
      chk("next_we", 16'(node_we), 16'h0);
    end else if (last_ok) begin
      chk("root_state", 16'(state), 16'h3);
      chk("root_busy", 16'(busy), 16'h1);
    end else begin
      chk("badroot_state", 16'(state), 16'h0);
      chk("badroot_err", 16'(error), 16'h2);
      chk("badroot_done", 16'(done), 16'h0);
      chk("badroot_busy", 16'(busy), 16'h0);
    end
  endtask

  initial begin
    int n;
    RST = 1'b1; start = 1'b0; abort = 1'b0; sym_valid = 1'b0; sym_last = 1'b0;
    merge_done = 1'b0; node_in = '0; code_done = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    RST = 1'b0;
    tick();

    // start coincident with abort is dropped
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_state", 16'(state), 16'h0);
    chk("start_abort_busy", 16'(busy), 16'h0);

    // normal frame
    we_seen = 0;
    begin_frame();
    count_syms(119, 1'b1);
    for (int k = 1; k <= 7; k++) do_merge(k, nodes_n[k-1], (k == 1), 1'b1);
    code_done = 1'b1;
    tick();
    code_done = 1'b0;
    chk("norm_done", 16'(done), 16'h1);
    chk("norm_state", 16'(state), 16'h0);
    chk("norm_busy", 16'(busy), 16'h0);
    chk("norm_err", 16'(error), 16'h0);
    chk("norm_cnt", 16'(sym_cnt), 16'd119);
    chk("norm_writes", 16'(we_seen), 16'd7);
    tick();
    chk("norm_done_pulse", 16'(done), 16'h0);

    // bad root
    begin_frame();
    count_syms(119, 1'b0);
    for (int k = 1; k <= 6; k++) do_merge(k, nodes_n[k-1], 1'b0, 1'b1);
    do_merge(7, 13'h0F77, 1'b0, 1'b0);
    tick();
    chk("badroot_done_after", 16'(done), 16'h0);

    // overflow on the 256th symbol
    begin_frame();
    sym_valid = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk("ovf_pre_cnt", 16'(sym_cnt), 16'd255);
    chk("ovf_pre_state", 16'(state), 16'h1);
    chk("ovf_pre_err", 16'(error), 16'h0);
    tick();
    sym_valid = 1'b0;
    chk("ovf_err", 16'(error), 16'h1);
    chk("ovf_state", 16'(state), 16'h0);
    chk("ovf_busy", 16'(busy), 16'h0);

    // timeout waiting on the third merge
    we_seen = 0;
    begin_frame();
    count_syms(119, 1'b0);
    do_merge(1, nodes_n[0], 1'b0, 1'b1);
    do_merge(2, nodes_n[1], 1'b0, 1'b1);
    tick();
    chk("to_wait_mreq", 16'(merge_req), 16'h0);
    n = 0;
    while (state == 2'b10 && n < 400) begin
      tick();
      n++;
    end
    chk("to_err", 16'(error), 16'h3);
    chk("to_state", 16'(state), 16'h0);
    chk("to_window", 16'(n >= 255 && n <= 256), 16'h1);
    chk("to_writes", 16'(we_seen), 16'd2);

    // abort in B_WAIT while merge_done is presented
    we_seen = 0;
    begin_frame();
    count_syms(5, 1'b0);
    tick();
    abort = 1'b1; merge_done = 1'b1; node_in = 13'h1F05;
    tick();
    abort = 1'b0; merge_done = 1'b0;
    chk("abort_state", 16'(state), 16'h0);
    chk("abort_we", 16'(node_we), 16'h0);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    chk("abort_err", 16'(error), 16'h0);
    chk("abort_writes", 16'(we_seen), 16'd0);

    // reset while in CODE
    begin_frame();
    count_syms(5, 1'b0);
    for (int k = 1; k <= 7; k++) do_merge(k, nodes_s[k-1], 1'b0, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_reset_vals("midrst");

    // clean frame after reset
    we_seen = 0;
    begin_frame();
    count_syms(5, 1'b0);
    for (int k = 1; k <= 7; k++) do_merge(k, nodes_s[k-1], 1'b0, 1'b1);
    code_done = 1'b1;
    tick();
    code_done = 1'b0;
    chk("clean_done", 16'(done), 16'h1);
    chk("clean_state", 16'(state), 16'h0);
    chk("clean_err", 16'(error), 16'h0);
    chk("clean_cnt", 16'(sym_cnt), 16'd5);
    chk("clean_writes", 16'(we_seen), 16'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
